// File: rtl/serial_word_tx.sv
// serial_word_tx: framed serial word transmitter (start, LSB-first data,
// optional even parity, stop), each bit held HOLD clocks.
// Optional feature macro: SERIAL_WORD_TX_PARITY_EN inserts an even-parity bit.
module serial_word_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned HOLD  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             data,
  output logic             busy,
  output logic             done
);

  localparam int unsigned HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int unsigned BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);
  // With HOLD=1 the first STOP cycle is also the last one
  localparam logic DONE_ON_STOP_ENTRY = (HOLD == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_WORD_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state;
  logic [HCW-1:0]   hold_cnt;
  logic [BCW-1:0]   bit_idx;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shift;
  logic [HCW-1:0]   hold_next;
  logic             hold_last;
`ifdef SERIAL_WORD_TX_PARITY_EN
  logic             parity;
`endif

  // Helpers for bit advance
  assign shreg_shift = shreg >> 1;
  assign hold_next   = hold_cnt + HCW'(1);
  assign hold_last   = (hold_cnt == HOLD_LAST);

  // Frame FSM with registered line and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      data     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b1;
`ifdef SERIAL_WORD_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            shreg    <= in_data;
`ifdef SERIAL_WORD_TX_PARITY_EN
            parity   <= ^in_data;
`endif
            hold_cnt <= '0;
            bit_idx  <= '0;
            state    <= S_START;
            data     <= 1'b1;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        S_START: begin
          if (hold_last) begin
            hold_cnt <= '0;
            state    <= S_DATA;
            data     <= shreg[0];
          end else begin
            hold_cnt <= hold_next;
          end
        end
        S_DATA: begin
          if (hold_last) begin
            hold_cnt <= '0;
            shreg    <= shreg_shift;
            if (bit_idx == BIT_LAST) begin
              bit_idx <= '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
              state   <= S_PARITY;
              data    <= parity;
`else
              state   <= S_STOP;
              data    <= 1'b0;
              done    <= DONE_ON_STOP_ENTRY;
`endif
            end else begin
              bit_idx <= bit_idx + BCW'(1);
              data    <= shreg_shift[0];
            end
          end else begin
            hold_cnt <= hold_next;
          end
        end
`ifdef SERIAL_WORD_TX_PARITY_EN
        S_PARITY: begin
          if (hold_last) begin
            hold_cnt <= '0;
            state    <= S_STOP;
            data     <= 1'b0;
            done     <= DONE_ON_STOP_ENTRY;
          end else begin
            hold_cnt <= hold_next;
          end
        end
`endif
        S_STOP: begin
          if (hold_last) begin
            hold_cnt <= '0;
            state    <= S_IDLE;
            data     <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            hold_cnt <= hold_next;
            done     <= (hold_next == HOLD_LAST);
          end
        end
        default: begin
          state    <= S_IDLE;
          hold_cnt <= '0;
          bit_idx  <= '0;
          data     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: directed bench for serial_word_tx (WIDTH=8/HOLD=2 and
// WIDTH=1/HOLD=1 instances); follows SERIAL_WORD_TX_PARITY_EN when defined.
module tb_serial_word_tx;

  localparam int unsigned W = 8;
  localparam int unsigned H = 2;
`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int unsigned F  = (W + 2 + (PAR ? 1 : 0)) * H;
  localparam int unsigned F1 = (1 + 2 + (PAR ? 1 : 0)) * 1;

  logic         clk;
  logic         reset;
  logic         in_valid, in_ready, data, busy, done;
  logic [W-1:0] in_data;
  logic         in_valid1, in_ready1, data1, busy1, done1;
  logic [0:0]   in_data1;

  int checks;
  int failures;

  serial_word_tx #(.WIDTH(W), .HOLD(H)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .data(data), .busy(busy), .done(done)
  );

  serial_word_tx #(.WIDTH(1), .HOLD(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .data(data1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock, settle 1 time unit after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level for frame cycle c (1-based) of a WIDTH=8/HOLD=2 frame
  function automatic logic exp_bit(input logic [W-1:0] word, input int c);
    int b;
    b = (c - 1) / int'(H);
    if (b == 0) return 1'b1;
    if (b <= int'(W)) return word[b-1];
    if (PAR && b == int'(W) + 1) return ^word;
    return 1'b0;
  endfunction

  // Checks the F frame cycles after an accept edge, then the idle cycle.
  // in_valid/in_data are set to keep_valid/mid_data for the whole frame.
  task automatic run_frame(input logic [W-1:0] word, input logic [W-1:0] mid_data,
                           input bit keep_valid, input string name);
    in_valid = keep_valid;
    in_data  = mid_data;
    for (int c = 1; c <= int'(F); c++) begin
      checks++;
      if (data !== exp_bit(word, c)) begin
        failures++;
        $display("FAIL %s data cycle T+%0d got=%b exp=%b", name, c, data, exp_bit(word, c));
      end
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s busy/in_ready cycle T+%0d got=%b/%b exp=1/0", name, c, busy, in_ready);
      end
      checks++;
      if (done !== (c == int'(F))) begin
        failures++;
        $display("FAIL %s done cycle T+%0d got=%b exp=%b", name, c, done, (c == int'(F)));
      end
      tick();
    end
    checks++;
    if (data !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL %s idle T+F+1 got data=%b busy=%b rdy=%b done=%b exp 0/0/1/0",
               name, data, busy, in_ready, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (data !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc%0d got data=%b rdy=%b busy=%b done=%b exp 0/1/0/0",
                 i, data, in_ready, busy, done);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (data !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d got data=%b rdy=%b busy=%b done=%b exp 0/1/0/0",
                 i, data, in_ready, busy, done);
      end
    end
  endtask

  task automatic test_single_word();
    in_data  = 8'hA5;
    in_valid = 1'b1;
    tick();
    // in_data changes mid-frame must not affect the latched word
    run_frame(8'hA5, 8'h5A, 1'b0, "single_a5");
    tick();
  endtask

  task automatic test_word_07();
    in_data  = 8'h07;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // Skip to cycle T+19 and check the slot after the last data bit directly
    for (int c = 1; c < 19; c++) tick();
    checks++;
    if (data !== (PAR ? 1'b1 : 1'b0)) begin
      failures++;
      $display("FAIL word07 T+19 got=%b exp=%b", data, PAR ? 1'b1 : 1'b0);
    end
    tick();
    checks++;
    if (data !== (PAR ? 1'b1 : 1'b0) || done !== (PAR ? 1'b0 : 1'b1)) begin
      failures++;
      $display("FAIL word07 T+20 got data=%b done=%b exp %b/%b", data, done,
               PAR ? 1'b1 : 1'b0, PAR ? 1'b0 : 1'b1);
    end
    for (int c = 21; c <= int'(F); c++) tick();
    checks++;
    if (done !== 1'b1 || data !== 1'b0) begin
      failures++;
      $display("FAIL word07 last cycle T+%0d got done=%b data=%b exp 1/0", F, done, data);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL word07 idle got rdy=%b busy=%b exp 1/0", in_ready, busy);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    run_frame(8'hFF, 8'h00, 1'b1, "b2b_first");
    // Now at T+F+1 with in_valid still high: this cycle is the second accept
    tick();
    run_frame(8'h00, 8'h00, 1'b0, "b2b_second");
    tick();
  endtask

  task automatic test_reset_mid_frame();
    in_data  = 8'h3C;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst busy T+7 got=%b exp=1", busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (data !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL midrst T+8 got data=%b busy=%b rdy=%b done=%b exp 0/0/1/0",
               data, busy, in_ready, done);
    end
    for (int c = 0; c < int'(F); c++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL midrst stale frame cyc%0d got done=%b busy=%b exp 0/0", c, done, busy);
      end
    end
    // Reset wins over a simultaneous accept
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h81;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || data !== 1'b0) begin
      failures++;
      $display("FAIL rst_priority got busy=%b data=%b exp 0/0", busy, data);
    end
    tick();
    in_data  = 8'h3C;
    in_valid = 1'b1;
    tick();
    run_frame(8'h3C, 8'hC3, 1'b0, "after_rst");
    tick();
  endtask

  task automatic test_corner_w1_h1();
    logic [3:0] exp_seq;
    exp_seq = PAR ? 4'b0111 : 4'b0011; // bit i = expected data at T+1+i
    in_data1  = 1'b1;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    for (int c = 1; c <= int'(F1); c++) begin
      checks++;
      if (data1 !== exp_seq[c-1] || done1 !== (c == int'(F1)) || busy1 !== 1'b1) begin
        failures++;
        $display("FAIL corner_w1h1 T+%0d got data=%b done=%b busy=%b exp %b/%b/1",
                 c, data1, done1, busy1, exp_seq[c-1], (c == int'(F1)));
      end
      tick();
    end
    checks++;
    if (in_ready1 !== 1'b1 || busy1 !== 1'b0 || data1 !== 1'b0) begin
      failures++;
      $display("FAIL corner_w1h1 idle got rdy=%b busy=%b data=%b exp 1/0/0",
               in_ready1, busy1, data1);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_valid1 = 1'b0;
    in_data1  = '0;
    #1;
    test_reset();
    test_single_word();
    test_word_07();
    test_back_to_back();
    test_reset_mid_frame();
    test_corner_w1_h1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
